// File: rtl/bus_serial_target_pkg.sv
// bus_serial_target_pkg: OCP command/response encodings and serial-link framing helpers
// Bus         : Ocp_cmd (IDLE/WR/RD), Ocp_resp (NULL/DVA/FAIL/ERR)
// Serial_link : beat_count/pad_bits framing math and the target FSM State enum
package Bus;
    typedef enum logic [2:0] {IDLE = 3'd0, WR = 3'd1, RD = 3'd2} Ocp_cmd;
    typedef enum logic [1:0] {NULL = 2'd0, DVA = 2'd1, FAIL = 2'd2, ERR = 2'd3} Ocp_resp;
endpackage

package Serial_link;
    function automatic int beat_count(input int w, input int sw);
        return (w + sw - 1) / sw;
    endfunction
    function automatic int pad_bits(input int w, input int sw);
        return (sw - w % sw) % sw;
    endfunction
    // S_RESET keeps rx_ready low until the first edge after reset releases
    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_RECEIVE, S_ISSUE, S_WAIT_RESP, S_TX_WAIT, S_TRANSMIT
    } State;
endpackage

// File: rtl/bus_serial_target_shifter.sv
// serial_frame_shifter: parallel-load, MSB-first shift register with a beat counter
// clk, reset          : clock, async active-high reset
// i_load / i_word     : load a W-bit word (LSB-padded to whole beats), clears counter
// i_shift / i_beat    : shift one SW-bit beat in at the LSB end, advance counter
// o_data              : RX=1 -> top W bits of the frame, RX=0 -> current outgoing beat
// o_last              : counter is on the terminal beat
module serial_frame_shifter
    import Serial_link::*;
#(
    parameter int SW = 4,
    parameter int W  = 8,
    parameter int RX = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_load,
    input  logic [W-1:0]                    i_word,
    input  logic                            i_shift,
    input  logic [SW-1:0]                   i_beat,
    output logic [(RX != 0 ? W : SW)-1:0]   o_data,
    output logic                            o_last
);
    localparam int N   = beat_count(W, SW);
    localparam int PAD = pad_bits(W, SW);
    localparam int FW  = N * SW;
    localparam int OW  = RX != 0 ? W : SW;
    localparam int CW  = $clog2(N + 1);

    logic [FW-1:0] r_word;
    logic [CW-1:0] r_ctr;
    logic [FW-1:0] w_shifted;

    generate
        if (N == 1) begin : g_single
            assign w_shifted = i_beat;
        end else begin : g_multi
            assign w_shifted = {r_word[FW-SW-1:0], i_beat};
        end
    endgenerate

    assign o_last = r_ctr == CW'(N - 1);
    assign o_data = r_word[FW-1 -: OW];

    // counter clears on the terminal beat so it never runs past N-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word <= '0;
            r_ctr  <= '0;
        end else if (i_load) begin
            r_word <= FW'(i_word) << PAD;
            r_ctr  <= '0;
        end else if (i_shift) begin
            r_word <= w_shifted;
            r_ctr  <= o_last ? '0 : r_ctr + 1'b1;
        end
    end
endmodule

// File: rtl/bus_serial_target.sv
// bus_serial_target: serial-link remote endpoint, deserializes commands to OCP and serializes responses back
// clk, reset                      : clock, async active-high reset
// rx_valid/rx_data/rx_ready       : command beats in, MSB-first
// tx_valid/tx_data/tx_ready       : response beats out, MSB-first
// MCmd/MAddr/MData/MByteEn        : OCP request to the local slave (MDataValid tied 0)
// SCmdAccept/SResp/SData          : OCP slave handshake and response
// MRespAccept                     : response accepted (idle or waiting)
// timeout                         : one-cycle pulse when an ERR response is synthesized
module bus_serial_target
    import Bus::*;
    import Serial_link::*;
#(
    parameter int SERIAL_WIDTH = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WRITE_RESP   = 1,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_valid,
    input  logic [SERIAL_WIDTH-1:0]   rx_data,
    output logic                      rx_ready,
    output logic                      tx_valid,
    output logic [SERIAL_WIDTH-1:0]   tx_data,
    input  logic                      tx_ready,
    output logic [2:0]                MCmd,
    output logic [ADDR_WIDTH-1:0]     MAddr,
    output logic [DATA_WIDTH-1:0]     MData,
    output logic [DATA_WIDTH/8-1:0]   MByteEn,
    output logic                      MDataValid,
    input  logic                      SCmdAccept,
    input  logic [1:0]                SResp,
    input  logic [DATA_WIDTH-1:0]     SData,
    output logic                      MRespAccept,
    output logic                      timeout
);
    localparam int W_CMD = 3 + ADDR_WIDTH + DATA_WIDTH + DATA_WIDTH / 8;
    localparam int W_RSP = 2 + DATA_WIDTH;
    localparam int TW    = RESP_TIMEOUT > 0 ? $clog2(RESP_TIMEOUT + 1) : 1;

    typedef struct packed {
        Ocp_cmd                  cmd;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] be;
    } Cmd_word;

    typedef struct packed {
        Ocp_resp               resp;
        logic [DATA_WIDTH-1:0] data;
    } Resp_word;

    State                    r_state;
    State                    w_next;
    logic [TW-1:0]           r_to_ctr;
    logic                    r_timeout;
    logic [W_CMD-1:0]        w_rx_word;
    Cmd_word                 w_cmd;
    Resp_word                w_resp;
    logic [SERIAL_WIDTH-1:0] w_tx_beat;
    logic                    w_rx_last;
    logic                    w_tx_last;
    logic                    w_rx_shift;
    logic                    w_tx_load;
    logic                    w_tx_shift;
    logic                    w_set_timeout;
    logic                    w_issue;
    logic                    w_resp_seen;
    logic                    w_to_hit;

    serial_frame_shifter #(.SW(SERIAL_WIDTH), .W(W_CMD), .RX(1)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .i_load  (1'b0),
        .i_word  ('0),
        .i_shift (w_rx_shift),
        .i_beat  (rx_data),
        .o_data  (w_rx_word),
        .o_last  (w_rx_last)
    );

    serial_frame_shifter #(.SW(SERIAL_WIDTH), .W(W_RSP), .RX(0)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_tx_load),
        .i_word  (w_resp),
        .i_shift (w_tx_shift),
        .i_beat  ('0),
        .o_data  (w_tx_beat),
        .o_last  (w_tx_last)
    );

    assign w_cmd       = Cmd_word'(w_rx_word);
    assign w_issue     = r_state == S_ISSUE;
    assign w_resp_seen = Ocp_resp'(SResp) != NULL;
    assign w_to_hit    = (RESP_TIMEOUT > 0) && (r_to_ctr == TW'(RESP_TIMEOUT - 1));

    assign rx_ready    = r_state == S_IDLE;
    assign MRespAccept = (r_state == S_IDLE) || (r_state == S_WAIT_RESP);
    assign MCmd        = w_issue ? w_cmd.cmd : IDLE;
    assign MAddr       = w_issue ? w_cmd.addr : '0;
    assign MData       = w_issue ? w_cmd.data : '0;
    assign MByteEn     = w_issue ? w_cmd.be : '0;
    assign MDataValid  = 1'b0;
    assign tx_valid    = r_state == S_TRANSMIT;
    assign tx_data     = tx_valid ? w_tx_beat : '0;
    assign timeout     = r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RESET;
            r_to_ctr  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_to_ctr  <= (RESP_TIMEOUT > 0 && r_state == S_WAIT_RESP) ? r_to_ctr + 1'b1 : '0;
            r_timeout <= w_set_timeout;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_rx_shift    = 1'b0;
        w_tx_load     = 1'b0;
        w_tx_shift    = 1'b0;
        w_set_timeout = 1'b0;
        w_resp        = '0;
        case (r_state)
            S_RESET: w_next = S_IDLE;
            // stale responses arriving here are accepted and dropped
            S_IDLE: begin
                if (rx_valid) begin
                    w_rx_shift = 1'b1;
                    w_next     = w_rx_last ? S_ISSUE : S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (rx_valid) begin
                    w_rx_shift = 1'b1;
                    w_next     = w_rx_last ? S_ISSUE : S_RECEIVE;
                end
            end
            S_ISSUE: begin
                if (w_cmd.cmd == IDLE)
                    w_next = S_IDLE;
                else if (SCmdAccept)
                    w_next = (w_cmd.cmd == RD || (w_cmd.cmd == WR && WRITE_RESP != 0)) ? S_WAIT_RESP : S_IDLE;
            end
            // a real response on the timeout edge takes priority
            S_WAIT_RESP: begin
                if (w_resp_seen) begin
                    w_tx_load = 1'b1;
                    w_resp    = '{resp: Ocp_resp'(SResp), data: SData};
                    w_next    = S_TX_WAIT;
                end else if (w_to_hit) begin
                    w_tx_load     = 1'b1;
                    w_set_timeout = 1'b1;
                    w_resp        = '{resp: ERR, data: '0};
                    w_next        = S_TX_WAIT;
                end
            end
            S_TX_WAIT: w_next = tx_ready ? S_TRANSMIT : S_TX_WAIT;
            S_TRANSMIT: begin
                w_tx_shift = 1'b1;
                w_next     = w_tx_last ? S_IDLE : S_TRANSMIT;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_bus_serial_target.sv
// tb_bus_serial_target: three bus_serial_target configurations driven by directed and random transactions
module tb_bus_serial_target;
    function automatic int f_sw(input int k); return k == 0 ? 4 : k == 1 ? 1 : 5; endfunction
    function automatic int f_aw(input int k); return k == 0 ? 32 : 8; endfunction
    function automatic int f_dw(input int k); return k == 0 ? 32 : 8; endfunction
    function automatic int f_wr(input int k); return k == 1 ? 0 : 1; endfunction
    function automatic int f_to(input int k); return k == 0 ? 8 : 0; endfunction

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [2:0] rxv = '0, txr = '0, sca = '0;
    logic [2:0][4:0] rxd = '0;
    logic [2:0][1:0] sresp = '0;
    logic [2:0][31:0] sdata = '0;
    wire [2:0] rxr, txv, mra, tmo, mdv;
    wire [2:0][4:0] txd;
    wire [2:0][2:0] mcmd;
    wire [2:0][31:0] maddr, mdata;
    wire [2:0][3:0] mbe;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SW = f_sw(g);
        localparam int AW = f_aw(g);
        localparam int DW = f_dw(g);
        logic [SW-1:0] t;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW/8-1:0] b;
        assign txd[g]   = 5'(t);
        assign maddr[g] = 32'(a);
        assign mdata[g] = 32'(d);
        assign mbe[g]   = 4'(b);
        bus_serial_target #(
            .SERIAL_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .WRITE_RESP(f_wr(g)), .RESP_TIMEOUT(f_to(g))
        ) dut (
            .clk(clk), .reset(reset),
            .rx_valid(rxv[g]), .rx_data(rxd[g][SW-1:0]), .rx_ready(rxr[g]),
            .tx_valid(txv[g]), .tx_data(t), .tx_ready(txr[g]),
            .MCmd(mcmd[g]), .MAddr(a), .MData(d), .MByteEn(b), .MDataValid(mdv[g]),
            .SCmdAccept(sca[g]), .SResp(sresp[g]), .SData(sdata[g][DW-1:0]),
            .MRespAccept(mra[g]), .timeout(tmo[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference framing: word left-aligned, zero-padded to whole beats, beat 0 = MSBs
    function automatic logic [127:0] cmd_vec(input int k, input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] d, input logic [3:0] b);
        logic [127:0] v = 128'(c);
        v = (v << f_aw(k)) | 128'(a);
        v = (v << f_dw(k)) | 128'(d);
        v = (v << (f_dw(k) / 8)) | 128'(b);
        return v;
    endfunction

    function automatic logic [4:0] beat_of(input logic [127:0] v, input int w, input int sw, input int i);
        int n = (w + sw - 1) / sw;
        logic [127:0] f = v << (n * sw - w);
        return 5'((f >> ((n - 1 - i) * sw)) & ((128'(1) << sw) - 1));
    endfunction

    task automatic send(input int k, input logic [127:0] v, input int w, input bit gaps, input int nb);
        int sw = f_sw(k);
        int n = (w + sw - 1) / sw;
        for (int i = 0; i < nb; i++) begin
            if (gaps && i > 0) begin
                rxv[k] = 1'b0;
                rxd[k] = 5'($urandom);
                @(negedge clk);
            end
            check(i == 0 ? "rx_ready idle" : "rx_ready busy", 64'(rxr[k]), 64'(i == 0));
            if (i == n - 1) check("early issue", 64'(mcmd[k]), 0);
            rxv[k] = 1'b1;
            rxd[k] = beat_of(v, w, sw, i);
            @(negedge clk);
        end
        rxv[k] = 1'b0;
        rxd[k] = '0;
    endtask

    task automatic txn(input int k, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit gaps, input int acc, input int rd,
                       input logic [1:0] rsp, input logic [31:0] rdata, input int tx_dly);
        int aw = f_aw(k), dw = f_dw(k), sw = f_sw(k), to = f_to(k);
        int wc = 3 + aw + dw + dw / 8, wr = 2 + dw;
        logic [31:0] dm = 32'((64'(1) << dw) - 1);
        bit timed, needs;
        logic [127:0] rv;
        a &= 32'((64'(1) << aw) - 1);
        d &= dm;
        rdata &= dm;
        b &= 4'((1 << (dw / 8)) - 1);
        send(k, cmd_vec(k, c, a, d, b), wc, gaps, (wc + sw - 1) / sw);
        check("MCmd", 64'(mcmd[k]), 64'(c));
        if (c == 3'd0) begin
            check("rx_ready in issue", 64'(rxr[k]), 0);
            @(negedge clk);
            check("idle frame dropped", 64'(rxr[k]), 1);
            return;
        end
        check("MAddr", 64'(maddr[k]), 64'(a));
        check("MData", 64'(mdata[k]), 64'(d));
        check("MByteEn", 64'(mbe[k]), 64'(b));
        check("MDataValid", 64'(mdv[k]), 0);
        for (int i = 0; i < acc; i++) begin
            @(negedge clk);
            check("hold MCmd", 64'(mcmd[k]), 64'(c));
            check("hold MAddr", 64'(maddr[k]), 64'(a));
            check("hold MData", 64'(mdata[k]), 64'(d));
        end
        sca[k] = 1'b1;
        @(negedge clk);
        sca[k] = 1'b0;
        check("MCmd after accept", 64'(mcmd[k]), 0);
        needs = (c == 3'd2) || (c == 3'd1 && f_wr(k) != 0);
        if (!needs) begin
            check("rx_ready no resp", 64'(rxr[k]), 1);
            repeat (2) @(negedge clk);
            check("no tx frame", 64'(txv[k]), 0);
            return;
        end
        timed = to > 0 && rd >= to;
        for (int i = 0; i < (timed ? to : rd); i++) begin
            check("timeout early", 64'(tmo[k]), 0);
            check("MRespAccept", 64'(mra[k]), 1);
            @(negedge clk);
        end
        if (!timed) begin
            sresp[k] = rsp;
            sdata[k] = rdata;
            @(negedge clk);
            sresp[k] = 2'd0;
            sdata[k] = $urandom;
        end
        check("timeout pulse", 64'(tmo[k]), 64'(timed));
        rv = timed ? (128'(2'd3) << dw) : ((128'(rsp) << dw) | 128'(rdata));
        for (int i = 0; i < tx_dly; i++) begin
            check("tx_valid while waiting", 64'(txv[k]), 0);
            @(negedge clk);
        end
        txr[k] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < (wr + sw - 1) / sw; i++) begin
            txr[k] = 1'($urandom);
            check("tx_valid", 64'(txv[k]), 1);
            check($sformatf("tx beat %0d", i), 64'(txd[k]), 64'(beat_of(rv, wr, sw, i)));
            if (i == 0) check("timeout one cycle", 64'(tmo[k]), 0);
            @(negedge clk);
        end
        txr[k] = 1'b0;
        check("tx done", 64'(txv[k]), 0);
        check("rx_ready after tx", 64'(rxr[k]), 1);
    endtask

    task automatic rand_txn(input int k, input int max_rd);
        logic [2:0] c = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 2));
        txn(k, c, $urandom, $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 3),
            $urandom_range(0, max_rd), 2'($urandom_range(1, 3)), $urandom, $urandom_range(0, 3));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset MCmd %0d", k), 64'(mcmd[k]), 0);
            check($sformatf("reset rx_ready %0d", k), 64'(rxr[k]), 0);
            check($sformatf("reset tx_valid %0d", k), 64'(txv[k]), 0);
            check($sformatf("reset tx_data %0d", k), 64'(txd[k]), 0);
            check($sformatf("reset MRespAccept %0d", k), 64'(mra[k]), 0);
            check($sformatf("reset timeout %0d", k), 64'(tmo[k]), 0);
        end
        reset = 1'b0;
        check("rx_ready before first edge", 64'(rxr[0]), 0);
        @(negedge clk);
        check("rx_ready after first edge", 64'(rxr[0]), 1);

        txn(0, 3'd2, 32'h1000_0040, 32'h0, 4'h0, 1'b0, 0, 2, 2'd1, 32'hDEAD_BEEF, 0);
        txn(0, 3'd1, 32'h20, 32'h1234_5678, 4'hF, 1'b0, 5, 1, 2'd1, 32'h0, 0);
        txn(0, 3'd2, 32'h44, 32'h0, 4'h0, 1'b0, 0, 30, 2'd1, 32'h0, 0);
        sresp[0] = 2'd1;
        sdata[0] = 32'hCAFE_F00D;
        check("stale resp accepted", 64'(mra[0]), 1);
        @(negedge clk);
        sresp[0] = 2'd0;
        check("stale resp dropped", 64'(rxr[0]), 1);
        txn(0, 3'd2, 32'h1000_0040, 32'h0, 4'h0, 1'b1, 0, 2, 2'd1, 32'hDEAD_BEEF, 0);
        txn(0, 3'd2, 32'h88, 32'h0, 4'h0, 1'b0, 1, 3, 2'd2, 32'h0BAD_CAFE, 10);
        txn(0, 3'd2, 32'h99, 32'h0, 4'h0, 1'b0, 0, 7, 2'd1, 32'h5A5A_A5A5, 0);

        send(0, cmd_vec(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF), 71, 1'b0, 7);
        reset = 1'b1;
        #1;
        check("mid reset MCmd", 64'(mcmd[0]), 0);
        check("mid reset rx_ready", 64'(rxr[0]), 0);
        check("mid reset tx_valid", 64'(txv[0]), 0);
        check("mid reset MRespAccept", 64'(mra[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rx_ready after mid reset", 64'(rxr[0]), 1);
        txn(0, 3'd1, 32'h3000_0000, 32'hA5A5_0F0F, 4'h5, 1'b0, 0, 0, 2'd1, 32'h0, 0);

        for (int r = 0; r < 16; r++) rand_txn(0, 12);

        txn(1, 3'd1, 32'hA5, 32'h3C, 4'h1, 1'b0, 2, 0, 2'd1, 32'h0, 0);
        txn(1, 3'd0, 32'h12, 32'h34, 4'h1, 1'b0, 0, 0, 2'd1, 32'h0, 0);
        txn(1, 3'd2, 32'h5A, 32'h0, 4'h0, 1'b1, 1, 2, 2'd1, 32'h96, 2);
        for (int r = 0; r < 6; r++) rand_txn(1, 4);

        txn(2, 3'd2, 32'hC3, 32'h0, 4'h0, 1'b0, 0, 1, 2'd3, 32'hE7, 0);
        txn(2, 3'd0, 32'h0, 32'h0, 4'h0, 1'b0, 0, 0, 2'd1, 32'h0, 0);
        txn(2, 3'd1, 32'h11, 32'h22, 4'h1, 1'b1, 3, 2, 2'd1, 32'h0, 1);
        for (int r = 0; r < 6; r++) rand_txn(2, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_serial_target.md
Name: bus_serial_target

Overview:
Remote (slave-side) endpoint of the serial bus link. It deserializes command frames arriving on an SERIAL_WIDTH-bit lane and issues them as OCP commands to a local slave. It captures the slave's response and serializes it back on the return lane. It pairs with a separate initiator endpoint that serializes commands and deserializes responses, so the link can span two clock-synchronous partitions.

Parameters:
SERIAL_WIDTH, 4, lane width in bits, for both rx and tx.
ADDR_WIDTH, 32, OCP address width.
DATA_WIDTH, 32, OCP data width; must be a multiple of 8.
WRITE_RESP, 1, when 1 a WR waits for SResp; when 0 a WR completes on SCmdAccept and sends no response frame.
RESP_TIMEOUT, 0, cycles to wait for SResp before synthesizing an ERR response; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  reset
rx_valid  in  1  command beat valid
rx_data  in  SERIAL_WIDTH  command beat, MSB-first
rx_ready  out  1  target can accept a new command frame
tx_valid  out  1  response beat valid
tx_data  out  SERIAL_WIDTH  response beat, MSB-first
tx_ready  in  1  initiator can accept a response frame
MCmd  out  3  Bus::Ocp_cmd
MAddr  out  ADDR_WIDTH
MData  out  DATA_WIDTH
MByteEn  out  DATA_WIDTH/8
MDataValid  out  1  tied 0
SCmdAccept  in  1
SResp  in  2  Bus::Ocp_resp
SData  in  DATA_WIDTH
MRespAccept  out  1
timeout  out  1  one-cycle pulse when a response is synthesized

Behaviour:
- Reset is asynchronous and active-high on clk. Every output is 0 in reset: MCmd=IDLE, MRespAccept=0, tx_valid=0, tx_data=0, timeout=0, rx_ready=0. rx_ready rises on the first clk edge after reset deasserts.
- Frame formats:
  - Command word is {MCmd, MAddr, MData, MByteEn}, W_CMD = 3+ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8.
  - Response word is {SResp, SData}, W_RSP = 2+DATA_WIDTH.
  - Each word is zero-padded at the LSB end to a multiple of SERIAL_WIDTH. Padding is (SW - W%SW)%SW, so a width that divides evenly gets no padding.
  - Beat count is N = ceil(W/SW). Beat 0 carries the word MSBs.
- FSM states:
  - S_IDLE
    - rx_ready=1; MRespAccept=1, and any SResp!=NULL seen here is stale and is dropped.
    - An rx_valid beat is stored as beat 0 and the FSM moves to S_RECEIVE.
    - If N_CMD==1, it goes straight to S_ISSUE.
  - S_RECEIVE
    - rx_ready=0. Beats are captured only in cycles where rx_valid=1; gaps are allowed and the counter holds.
    - The edge that captures beat N_CMD-1 moves the FSM to S_ISSUE.
    - rx_valid outside S_IDLE/S_RECEIVE is ignored.
  - S_ISSUE
    - MCmd/MAddr/MData/MByteEn are driven from the frame register and stay stable until the edge where SCmdAccept=1.
    - If the decoded MCmd==IDLE, no command is driven and the FSM returns to S_IDLE on the next cycle.
    - On accept: a RD, or a WR with WRITE_RESP=1, goes to S_WAIT_RESP. A WR with WRITE_RESP=0 goes to S_IDLE.
  - S_WAIT_RESP
    - MRespAccept=1. On the first edge with SResp!=NULL, {SResp, SData} is captured and the FSM goes to S_TX_WAIT.
    - With RESP_TIMEOUT>0, a counter clears on entry. When it reaches RESP_TIMEOUT with no response, the FSM captures {ERR, 0}, pulses timeout for one cycle and goes to S_TX_WAIT.
    - A response on the same edge as the timeout wins, and timeout does not pulse.
  - S_TX_WAIT
    - tx_valid=0. Moves to S_TRANSMIT on the edge where tx_ready=1.
  - S_TRANSMIT
    - tx_valid=1 and tx_data=beat[ctr] for N_RSP consecutive cycles; tx_ready is not re-sampled during the frame.
    - After the last beat, the FSM goes to S_IDLE.
- Outputs are decoded only from registers (state, counters, word registers). There is no combinational input-to-output path except MRespAccept/rx_ready, which are state-decoded.
- Latency:
  - MCmd is valid in the cycle after the edge that captured the last command beat.
  - tx_valid rises in the cycle after the edge that samples tx_ready=1 in S_TX_WAIT.
- A new command frame is accepted only after the response frame completes (one outstanding transaction).
- Reset asserted mid-frame or mid-transaction aborts the transaction immediately. The partial frame is discarded and all outputs return to reset values.
- Beat counters are clog2(N+1) bits wide and clear on the terminal beat; they never wrap past N-1.

Decomposition:
- Package Bus (existing): Ocp_cmd (3 bits: IDLE=0, WR=1, RD=2) and Ocp_resp (2 bits: NULL=0, DVA=1, FAIL=2, ERR=3).
- New package Serial_link:
  - a function computing beat count and padding from (W, SW);
  - packed structs Cmd_word and Resp_word, parameterised through the instantiating module's typedefs;
  - the State enum.
- One sub-module, serial_frame_shifter: a parallel-load, MSB-first shift register with a beat counter. It is used twice, in receive mode and in transmit mode.

Test Plan:
- SW=4, ADDR/DATA=32 (N_CMD=18, N_RSP=9, pad 1/2). RD frame addr 0x1000_0040 → MCmd=RD and MAddr=0x10000040 the cycle after beat 18; slave returns DVA/0xDEADBEEF → 9 tx beats, MSB-first, last beat 0xC (2 pad bits zero); rx_ready=1 afterward.
- WR addr 0x20 data 0x12345678 byteen 0xF, SCmdAccept held low 5 cycles → MCmd/MAddr/MData stable all 5 cycles. With WRITE_RESP=0 → no tx frame, rx_ready=1 the cycle after accept.
- RESP_TIMEOUT=8, slave never responds → timeout pulses 8 cycles after accept, tx frame carries {ERR, 0}. A later SResp=DVA in S_IDLE is accepted and dropped.
- rx_valid toggling 1/0 every cycle during a frame → identical issued command to the contiguous case; frame completes after 36 cycles.
- tx_ready low 10 cycles in S_TX_WAIT → tx_valid stays 0, then 9 contiguous beats. Reset pulse mid-S_RECEIVE (beat 7) → MCmd=IDLE, the next full frame decodes correctly.
- SW=1, DATA=8, ADDR=8 (W_CMD=20, N=20) plus SW=5 with an evenly dividing width → padding math and MCmd=IDLE frame discard (no MCmd asserted, S_IDLE next cycle).
